// File: rtl/scoreboard_pkg.sv
// Shared constants for the scoreboard renderer: 3x5 digit font, converter FSM states
// and the per-player pixel-locator record passed between the two pixel stages.
package scoreboard_pkg;

  localparam int GLYPH_W = 3;
  localparam int GLYPH_H = 5;

  // Row-major 3x5 glyphs, bit 14 is the top-left cell; entry 0 sits in the LSBs.
  localparam logic [9:0][14:0] GLYPH_ROM = {
    15'b111_101_111_001_111,  // 9
    15'b111_101_111_101_111,  // 8
    15'b111_001_001_001_001,  // 7
    15'b111_100_111_101_111,  // 6
    15'b111_100_111_001_111,  // 5
    15'b101_101_111_001_001,  // 4
    15'b111_001_111_001_111,  // 3
    15'b111_001_111_100_111,  // 2
    15'b010_110_010_010_111,  // 1
    15'b111_101_101_101_111   // 0
  };

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, STORE} state_t;

  typedef struct packed {
    logic       hit;
    logic [1:0] dig;
    logic [2:0] row;
    logic [1:0] col;
  } pix_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// One-bit-per-cycle double-dabble converter with start/done handshake; values above
// 10^DIGITS-1 read back as all nines.
module bin2bcd_seq #(
  parameter int SCORE_W = 7,
  parameter int DIGITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [SCORE_W-1:0]    bin_i,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o
);
  localparam int BW   = 4 * DIGITS;
  localparam int CW   = $clog2(SCORE_W + 1);
  localparam int MAXV = 10**DIGITS - 1;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               sat_q, sat_d;

  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int k = 0; k < DIGITS; k++)
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    return r;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    sat_d = sat_q;
    if (start_i) begin
      cnt_d = CW'(SCORE_W);
      bin_d = bin_i;
      bcd_d = '0;
      sat_d = (32'(bin_i) > 32'(MAXV));
    end else if (cnt_q != '0) begin
      {bcd_d, bin_d} = {add3(bcd_q), bin_q} << 1;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  always_ff @(posedge clk) begin
    bin_q <= bin_d;
    bcd_q <= bcd_d;
    sat_q <= sat_d;
  end

  assign done_o = (cnt_q == CW'(1)) && !start_i;
  assign bcd_o  = sat_q ? {DIGITS{4'd9}} : bcd_q;

endmodule

// File: rtl/scoreboard_render.sv
// Multi-player BCD score renderer with a 2-cycle pixel pipeline.
// Optional score-change flashing is enabled by defining SCOREBOARD_FLASH_EN.
module scoreboard_render
  import scoreboard_pkg::*;
#(
  parameter int                         NUM_PLAYERS  = 2,
  parameter int                         DIGITS       = 2,
  parameter int                         SCORE_W      = 7,
  parameter int                         SCALE_LOG2   = 1,
  parameter int                         X0           = 40,
  parameter int                         Y0           = 4,
  parameter int                         PLAYER_PITCH = 60,
  parameter logic [3*NUM_PLAYERS-1:0]   PLAYER_COLOR = {3'b010, 3'b100},
  parameter logic [2:0]                 FLASH_COLOR  = 3'b111,
  parameter int                         FLASH_FRAMES = 32
) (
  input  logic                          VGA_CLK,
  input  logic                          reset,
  input  logic [7:0]                    xvga,
  input  logic [6:0]                    yvga,
  input  logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [NUM_PLAYERS-1:0]        display,
  output logic [3*NUM_PLAYERS-1:0]      color,
  output logic                          busy
);
  localparam int CELL = 1 << SCALE_LOG2;
  localparam int PW   = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  logic [6:0]          yvga_prev_q;
  logic                frame_start;
  state_t              state_q, state_d;
  logic [PW-1:0]       p_q, p_d;
  logic [SCORE_W-1:0]  snap_q [NUM_PLAYERS];
  logic [4*DIGITS-1:0] bcd_q  [NUM_PLAYERS];
  logic                eng_done;
  logic [4*DIGITS-1:0] eng_bcd;
  logic [NUM_PLAYERS-1:0]   flashing;
  pix_t                     pix_p1 [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0]   disp_d;
  logic [3*NUM_PLAYERS-1:0] color_d;

  assign frame_start = (yvga_prev_q != 7'd0) && (yvga == 7'd0);

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    case (state_q)
      IDLE:  ;
      LOAD:  state_d = SHIFT;
      SHIFT: if (eng_done) state_d = STORE;
      STORE: begin
        if (p_q == PW'(NUM_PLAYERS - 1)) state_d = IDLE;
        else begin
          state_d = LOAD;
          p_d     = p_q + PW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A new frame always restarts from player 0 with the fresh snapshot.
    if (frame_start) begin
      state_d = LOAD;
      p_d     = '0;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      yvga_prev_q <= '0;
      state_q     <= IDLE;
      p_q         <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        snap_q[p] <= '0;
        bcd_q[p]  <= '0;
      end
    end else begin
      yvga_prev_q <= yvga;
      state_q     <= state_d;
      p_q         <= p_d;
      if (frame_start)
        for (int p = 0; p < NUM_PLAYERS; p++) snap_q[p] <= score[p*SCORE_W +: SCORE_W];
      if (state_q == STORE) bcd_q[p_q] <= eng_bcd;
    end
  end

  bin2bcd_seq #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_bcd (
    .clk     (VGA_CLK),
    .rst     (reset),
    .start_i (state_q == LOAD),
    .bin_i   (snap_q[p_q]),
    .done_o  (eng_done),
    .bcd_o   (eng_bcd)
  );

`ifdef SCOREBOARD_FLASH_EN
  localparam int FCW = $clog2(FLASH_FRAMES + 1);
  logic               frame_start_q;
  logic [SCORE_W-1:0] prev_q  [NUM_PLAYERS];
  logic [FCW-1:0]     flash_q [NUM_PLAYERS];

  // Runs one cycle behind frame start so snap_q already holds the new snapshot.
  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      frame_start_q <= 1'b0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        prev_q[p]  <= '0;
        flash_q[p] <= '0;
      end
    end else begin
      frame_start_q <= frame_start;
      if (frame_start_q)
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          prev_q[p] <= snap_q[p];
          if (snap_q[p] != prev_q[p]) flash_q[p] <= FCW'(FLASH_FRAMES);
          else if (flash_q[p] != '0)  flash_q[p] <= flash_q[p] - FCW'(1);
        end
    end
  end

  always_comb
    for (int p = 0; p < NUM_PLAYERS; p++)
      flashing[p] = (flash_q[p] != '0) && flash_q[p][2];
`else
  assign flashing = '0;
`endif

  function automatic pix_t locate(input int p, input int x, input int y);
    pix_t r;
    int   dx, dy;
    r  = '0;
    dy = y - Y0;
    for (int d = 0; d < DIGITS; d++) begin
      dx = x - (X0 + p*PLAYER_PITCH + d*4*CELL);
      if (dx >= 0 && dx < GLYPH_W*CELL && dy >= 0 && dy < GLYPH_H*CELL) begin
        r.hit = 1'b1;
        r.dig = 2'(d);
        r.row = 3'(dy >>> SCALE_LOG2);
        r.col = 2'(dx >>> SCALE_LOG2);
      end
    end
    return r;
  endfunction

  // Zero digits above the first nonzero one stay dark; the units digit always shows.
  function automatic logic glyph_lit(input logic [4*DIGITS-1:0] bcd, input pix_t px);
    logic [3:0]  nib;
    logic [14:0] bits;
    logic        lead_zero;
    lead_zero = 1'b1;
    nib       = '0;
    for (int d = 0; d < DIGITS; d++)
      if (d <= int'(px.dig)) begin
        nib = 4'(bcd >> (4*(DIGITS-1-d)));
        if (nib != 4'd0) lead_zero = 1'b0;
      end
    if (!px.hit || nib > 4'd9) return 1'b0;
    if (lead_zero && int'(px.dig) != DIGITS-1) return 1'b0;
    bits = GLYPH_ROM[nib] << (int'(px.row)*GLYPH_W + int'(px.col));
    return bits[14];
  endfunction

  // Stage 1: field/digit hit, glyph row/col and digit select
  always_ff @(posedge VGA_CLK)
    for (int p = 0; p < NUM_PLAYERS; p++) pix_p1[p] <= locate(p, int'(xvga), int'(yvga));

  // Stage 2: ROM bit, blanking and colour
  always_comb begin
    disp_d  = '0;
    color_d = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      disp_d[p]        = glyph_lit(bcd_q[p], pix_p1[p]);
      color_d[3*p +: 3] = flashing[p] ? FLASH_COLOR : PLAYER_COLOR[3*p +: 3];
    end
  end

  always_ff @(posedge VGA_CLK) begin
    if (reset) begin
      display <= '0;
      color   <= '0;
    end else begin
      display <= disp_d;
      color   <= color_d;
    end
  end

endmodule

// File: tb/tb_scoreboard_render.sv
// Bench for scoreboard_render at default parameters: table of score pairs swept over
// the score area through a pipeline scoreboard, plus busy/restart/reset/flash sequences.
module tb_scoreboard_render;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  xvga;
  logic [6:0]  yvga;
  logic [13:0] score;
  logic [1:0]  display;
  logic [5:0]  color;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int shown[2];
  int last_snap[2];
  int fl_cnt[2];

  typedef struct { int s0; int s1; int e0; int e1; } vec_t;
  typedef struct { logic [1:0] disp; int x; int y; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  scoreboard_render dut (
    .VGA_CLK (clk),
    .reset   (reset),
    .xvga    (xvga),
    .yvga    (yvga),
    .score   (score),
    .display (display),
    .color   (color),
    .busy    (busy)
  );

  function automatic logic [14:0] font(input int d);
    case (d)
      0: return 15'b111_101_101_101_111;
      1: return 15'b010_110_010_010_111;
      2: return 15'b111_001_111_100_111;
      3: return 15'b111_001_111_001_111;
      4: return 15'b101_101_111_001_001;
      5: return 15'b111_100_111_001_111;
      6: return 15'b111_100_111_101_111;
      7: return 15'b111_001_001_001_001;
      8: return 15'b111_101_111_101_111;
      default: return 15'b111_101_111_001_111;
    endcase
  endfunction

  function automatic logic exp_pix(input int p, input int x, input int y);
    int tens, units, ox, dx, dy, dig;
    logic [14:0] g;
    tens  = shown[p] / 10;
    units = shown[p] % 10;
    ox    = 40 + p*60;
    dy    = y - 4;
    if (dy < 0 || dy >= 10) return 1'b0;
    for (int d = 0; d < 2; d++) begin
      dx = x - (ox + d*8);
      if (dx >= 0 && dx < 6) begin
        if (d == 0 && tens == 0) return 1'b0;
        dig = (d == 0) ? tens : units;
        g   = font(dig);
        return g[14 - ((dy/2)*3 + dx/2)];
      end
    end
    return 1'b0;
  endfunction

  function automatic int exp_color(input int p);
    int base;
    base = (p == 0) ? 4 : 2;
`ifdef SCOREBOARD_FLASH_EN
    if (fl_cnt[p] != 0 && (fl_cnt[p] & 4) != 0) return 7;
`endif
    return base;
  endfunction

  function automatic void model_frame(input int s0, input int s1);
    int v;
    for (int p = 0; p < 2; p++) begin
      v = (p == 0) ? s0 : s1;
      if (v != last_snap[p]) fl_cnt[p] = 32;
      else if (fl_cnt[p] > 0) fl_cnt[p] = fl_cnt[p] - 1;
      last_snap[p] = v;
    end
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      shown[p] = 0; last_snap[p] = 0; fl_cnt[p] = 0;
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame(input int s0, input int s1);
    score = {7'(s1), 7'(s0)};
    yvga  = 7'd1;
    step();
    yvga  = 7'd0;
    step();
    model_frame(s0, s1);
    yvga  = 7'd20;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      step();
      n++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic pop_check();
    exp_t e;
    e = sb.pop_front();
    chk($sformatf("pix x=%0d y=%0d", e.x, e.y), int'(display), int'(e.disp));
  endtask

  task automatic sweep();
    exp_t e;
    for (int y = 3; y <= 14; y++)
      for (int x = 38; x <= 116; x++) begin
        xvga   = 8'(x);
        yvga   = 7'(y);
        e.x    = x;
        e.y    = y;
        e.disp = {exp_pix(1, x, y), exp_pix(0, x, y)};
        sb.push_back(e);
        step();
        if (sb.size() >= 2) pop_check();
      end
    step();
    while (sb.size() > 0) pop_check();
    yvga = 7'd20;
    chk("color_p0", int'(color[2:0]), exp_color(0));
    chk("color_p1", int'(color[5:3]), exp_color(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    vecs[0] = '{s0: 0,   s1: 0,   e0: 0,  e1: 0};
    vecs[1] = '{s0: 42,  s1: 7,   e0: 42, e1: 7};
    vecs[2] = '{s0: 120, s1: 5,   e0: 99, e1: 5};
    vecs[3] = '{s0: 99,  s1: 100, e0: 99, e1: 99};
    vecs[4] = '{s0: 9,   s1: 10,  e0: 9,  e1: 10};

    model_reset();
    reset = 1'b1;
    xvga  = 8'd44;
    yvga  = 7'd50;
    score = {7'd7, 7'd42};
    repeat (3) step();
    chk("rst_display", int'(display), 0);
    chk("rst_color",   int'(color),   0);
    chk("rst_busy",    int'(busy),    0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      do_frame(vecs[i].s0, vecs[i].s1);
      wait_idle();
      shown[0] = vecs[i].e0;
      shown[1] = vecs[i].e1;
      sweep();
    end

    // Busy timing and abort/restart on a second frame start 10 cycles in.
    score = {7'd22, 7'd11};
    yvga  = 7'd1;
    step();
    yvga  = 7'd0;
    chk("busy_fs_cycle", int'(busy), 0);
    step();
    model_frame(11, 22);
    chk("busy_c1", int'(busy), 1);
    for (int i = 2; i <= 9; i++) begin
      step();
      chk($sformatf("busy_c%0d", i), int'(busy), 1);
    end
    score = {7'd44, 7'd33};
    yvga  = 7'd1;
    step();
    chk("busy_c10", int'(busy), 1);
    yvga  = 7'd0;
    step();
    model_frame(33, 44);
    yvga  = 7'd20;
    chk("busy_r1", int'(busy), 1);
    for (int i = 2; i <= 18; i++) begin
      step();
      chk($sformatf("busy_r%0d", i), int'(busy), 1);
    end
    step();
    chk("busy_r_end", int'(busy), 0);
    shown[0] = 33;
    shown[1] = 44;
    sweep();

    // Reset mid-conversion clears committed values.
    do_frame(55, 66);
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("midrst_busy", int'(busy), 0);
    reset = 1'b0;
    model_reset();
    step();
    chk("midrst_busy2", int'(busy), 0);
    sweep();

    // Field corner latency.
    do_frame(42, 7);
    wait_idle();
    shown[0] = 42;
    shown[1] = 7;
    xvga = 8'd0;
    yvga = 7'd20;
    step();
    step();
    xvga = 8'd40;
    yvga = 7'd4;
    step();
    chk("corner_lat1", int'(display[0]), int'(exp_pix(0, 0, 20)));
    step();
    chk("corner_lat2", int'(display[0]), int'(exp_pix(0, 40, 4)));
    yvga = 7'd20;

    // Player 1 changes 3 -> 4, then 38 further frames.
    do_frame(5, 3);
    do_frame(5, 3);
    for (int f = 0; f < 38; f++) begin
      do_frame(5, 4);
      repeat (4) step();
      chk($sformatf("flash_p1_f%0d", f), int'(color[5:3]), exp_color(1));
      chk($sformatf("flash_p0_f%0d", f), int'(color[2:0]), exp_color(0));
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
